// File: rtl/metaballs_pkg.sv
// Shared types, VGA constants and the falloff table for the metaball renderer.
// The falloff LUT is a constant function; callers evaluate it at elaboration time only.
package metaballs_pkg;

  localparam int SCREEN_W  = 800;
  localparam int SCREEN_H  = 600;
  localparam int H_FRONT   = 56;
  localparam int H_SYNC    = 120;
  localparam int H_BACK    = 64;
  localparam int H_TOTAL   = 1040;
  localparam int V_FRONT   = 37;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = 666;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t pos;
    logic   dir;   // 1 = increasing coordinate
  } axis_t;

  // Quadrant falloff, idx = {qy,qx}; 15 is the ball centre on each axis.
  // 2 + 169*(91/(91+d2))^3 gives 0xab at the centre, 0x06 on an axis edge, 0x02 at the corner.
  function automatic logic [7:0] falloff_lut(input logic [7:0] idx);
    longint dx, dy, d2, den;
    dx  = 15 - longint'(idx[3:0]);
    dy  = 15 - longint'(idx[7:4]);
    d2  = dx * dx + dy * dy;
    den = (91 + d2) * (91 + d2) * (91 + d2);
    return 8'(2 + (longint'(127353499) / den));
  endfunction

  function automatic coord_t abs_diff11(input coord_t a, input coord_t b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? coord_t'(-d) : coord_t'(d);
  endfunction

  // One frame of motion on one axis, clamping to [lo, hi] and reversing there.
  function automatic axis_t bounce(input axis_t a, input int speed, input int lo, input int hi);
    logic [10:0] n;
    bounce = a;
    n = a.dir ? {1'b0, a.pos} + 11'(speed) : {1'b0, a.pos} - 11'(speed);
    if (a.dir && n >= 11'(hi)) begin
      bounce.pos = coord_t'(hi);
      bounce.dir = 1'b0;
    end else if (!a.dir && n <= 11'(lo)) begin
      bounce.pos = coord_t'(lo);
      bounce.dir = 1'b1;
    end else begin
      bounce.pos = n[9:0];
    end
  endfunction

endpackage

// File: rtl/metaball_field_ball_unit.sv
// One bouncing ball: frame-rate motion plus pipeline stages S1 (distance) and S2 (LUT lookup).
module metaball_ball_unit
  import metaballs_pkg::*;
#(
  parameter coord_t START_X   = 10'd400,
  parameter coord_t START_Y   = 10'd300,
  parameter int     SPEED     = 5,
  parameter int     HALF_SPAN = 32,
  parameter int     SCR_W     = 800,
  parameter int     SCR_H     = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hold,
  input  coord_t     x,
  input  coord_t     y,
  output logic [7:0] c
);

  localparam int     SH = $clog2(HALF_SPAN) - 4;
  localparam coord_t HS = coord_t'(HALF_SPAN);

  logic [7:0] lut [256];
  for (genvar i = 0; i < 256; i++) begin : g_lut
    localparam logic [7:0] LV = falloff_lut(8'(i));
    assign lut[i] = LV;
  end

  axis_t      bx_q, bx_d, by_q, by_d;
  logic       in_q, in_d;
  logic [3:0] nx_q, nx_d, ny_q, ny_d;
  logic [7:0] c_q, c_d;
  coord_t     ax, ay;

  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    if (frame_tick && !hold) begin
      bx_d = bounce(bx_q, SPEED, HALF_SPAN, SCR_W - HALF_SPAN);
      by_d = bounce(by_q, SPEED, HALF_SPAN, SCR_H - HALF_SPAN);
    end
    // S1: only the nibble the LUT needs survives the register.
    ax   = abs_diff11(x, bx_q.pos);
    ay   = abs_diff11(y, by_q.pos);
    in_d = (ax < HS) && (ay < HS);
    nx_d = ax[SH +: 4];
    ny_d = ay[SH +: 4];
    // S2
    c_d  = in_q ? lut[{4'd15 - ny_q, 4'd15 - nx_q}] : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_q <= '{pos: START_X, dir: 1'b1};
      by_q <= '{pos: START_Y, dir: 1'b1};
      in_q <= 1'b0;
      nx_q <= '0;
      ny_q <= '0;
      c_q  <= '0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      in_q <= in_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
      c_q  <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: rtl/metaball_field.sv
// Multi-ball metaball renderer: per-ball units, frame tick from v_sync, saturating sum and threshold.
module metaball_field
  import metaballs_pkg::*;
#(
  parameter int                     NUM_BALLS     = 4,
  parameter int                     SCREEN_WIDTH  = 800,
  parameter int                     SCREEN_HEIGHT = 600,
  parameter int                     HALF_SPAN     = 32,
  parameter int                     BALL_SPEED    = 5,
  parameter logic [NUM_BALLS*10-1:0] START_X      = {10'd100, 10'd300, 10'd500, 10'd700},
  parameter logic [NUM_BALLS*10-1:0] START_Y      = {10'd100, 10'd250, 10'd400, 10'd500},
  parameter int                     SUM_WIDTH     = 9,
  parameter int                     THRESHOLD     = 10
) (
  input  logic                 clk_50mhz,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 display,
  input  logic                 v_sync,
  input  logic                 hold,
  output logic                 rgb,
  output logic                 display_out,
  output logic [SUM_WIDTH-1:0] field_sum
);

  typedef logic [SUM_WIDTH+2:0] acc_t;
  localparam acc_t                 SAT_MAX = acc_t'((1 << SUM_WIDTH) - 1);
  localparam logic [SUM_WIDTH-1:0] THR     = THRESHOLD[SUM_WIDTH-1:0];

  logic                          v_sync_prev_q, frame_tick;
  logic [NUM_BALLS-1:0][7:0]     contrib;
  logic [1:0]                    disp_pipe_q, disp_pipe_d;
  logic                          rgb_q, rgb_d, disp_out_q, disp_out_d;
  logic [SUM_WIDTH-1:0]          sum_q, sum_d;
  acc_t                          sum_raw;

  assign frame_tick = v_sync_prev_q & ~v_sync;

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
    metaball_ball_unit #(
      .START_X  (START_X[i*10 +: 10]),
      .START_Y  (START_Y[i*10 +: 10]),
      .SPEED    (BALL_SPEED),
      .HALF_SPAN(HALF_SPAN),
      .SCR_W    (SCREEN_WIDTH),
      .SCR_H    (SCREEN_HEIGHT)
    ) u_ball (
      .clk       (clk_50mhz),
      .rst       (reset),
      .frame_tick(frame_tick),
      .hold      (hold),
      .x         (x),
      .y         (y),
      .c         (contrib[i])
    );
  end

  always_comb begin
    sum_raw = '0;
    for (int i = 0; i < NUM_BALLS; i++) sum_raw = sum_raw + acc_t'(contrib[i]);
    sum_d       = (sum_raw > SAT_MAX) ? SAT_MAX[SUM_WIDTH-1:0] : sum_raw[SUM_WIDTH-1:0];
    disp_pipe_d = {disp_pipe_q[0], display};
    disp_out_d  = disp_pipe_q[1];
    rgb_d       = disp_pipe_q[1] && (sum_d > THR);
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      v_sync_prev_q <= 1'b1;
      disp_pipe_q   <= '0;
      disp_out_q    <= 1'b0;
      rgb_q         <= 1'b0;
      sum_q         <= '0;
    end else begin
      v_sync_prev_q <= v_sync;
      disp_pipe_q   <= disp_pipe_d;
      disp_out_q    <= disp_out_d;
      rgb_q         <= rgb_d;
      sum_q         <= sum_d;
    end
  end

  assign rgb         = rgb_q;
  assign display_out = disp_out_q;
  assign field_sum   = sum_q;

endmodule

// File: tb/tb_metaball_field.sv
// Directed bench: three renderer configurations sharing the raster inputs.
module tb_metaball_field;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = '0, y = '0;
  logic       display = 1'b0;
  logic       vs_idle = 1'b1, vs_c = 1'b1, hold_c = 1'b0, hold_off = 1'b0;

  logic       a_rgb, a_dout, b_rgb, b_dout, c_rgb, c_dout;
  logic [8:0] a_sum, c_sum;
  logic [7:0] b_sum;

  int n_vec = 0, n_err = 0;

  always #10 clk = ~clk;

  metaball_field #(.NUM_BALLS(1), .START_X(10'd400), .START_Y(10'd300)) dut_a (
    .clk_50mhz(clk), .reset(reset), .x(x), .y(y), .display(display), .v_sync(vs_idle),
    .hold(hold_off), .rgb(a_rgb), .display_out(a_dout), .field_sum(a_sum));

  metaball_field #(.NUM_BALLS(2), .START_X({10'd400, 10'd400}), .START_Y({10'd300, 10'd300}),
                   .SUM_WIDTH(8)) dut_b (
    .clk_50mhz(clk), .reset(reset), .x(x), .y(y), .display(display), .v_sync(vs_idle),
    .hold(hold_off), .rgb(b_rgb), .display_out(b_dout), .field_sum(b_sum));

  metaball_field #(.NUM_BALLS(1), .START_X(10'd765), .START_Y(10'd300)) dut_c (
    .clk_50mhz(clk), .reset(reset), .x(x), .y(y), .display(display), .v_sync(vs_c),
    .hold(hold_c), .rgb(c_rgb), .display_out(c_dout), .field_sum(c_sum));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic probe(input int px, input int py, input logic d);
    @(negedge clk);
    x = 10'(px); y = 10'(py); display = d;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk) vs_c = 1'b0;
    @(negedge clk) vs_c = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int ex, ey;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(a_rgb), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_sum", 32'(a_sum), 0);
    @(negedge clk) reset = 1'b0;

    // latency: far pixel, then centre; output must still be 0 two edges later
    probe(0, 0, 1'b1);
    chk("far_sum", 32'(a_sum), 0);
    @(negedge clk);
    x = 10'd400; y = 10'd300;
    repeat (2) @(posedge clk);
    #1;
    chk("lat2_sum", 32'(a_sum), 0);
    @(posedge clk);
    #1;
    chk("ctr_sum", 32'(a_sum), 32'h0ab);
    chk("ctr_rgb", 32'(a_rgb), 1);
    chk("ctr_dout", 32'(a_dout), 1);

    probe(432, 300, 1'b1);
    chk("edge32_sum", 32'(a_sum), 0);
    chk("edge32_rgb", 32'(a_rgb), 0);
    probe(431, 300, 1'b1);
    chk("edge31_sum", 32'(a_sum), 6);
    chk("edge31_rgb", 32'(a_rgb), 0);
    probe(400, 269, 1'b1);
    chk("edgey_sum", 32'(a_sum), 6);
    probe(400, 300, 1'b1);
    chk("sat_sum", 32'(b_sum), 32'hff);
    chk("sat_rgb", 32'(b_rgb), 1);
    probe(400, 300, 1'b0);
    chk("blank_rgb_b", 32'(b_rgb), 0);
    chk("blank_sum_b", 32'(b_sum), 32'hff);
    chk("blank_rgb_a", 32'(a_rgb), 0);
    chk("blank_dout", 32'(a_dout), 0);

    // motion on dut_c
    tick();
    probe(768, 305, 1'b1);
    chk("bounce_hi", 32'(c_sum), 32'h0ab);
    tick();
    probe(763, 310, 1'b1);
    chk("after_hi", 32'(c_sum), 32'h0ab);
    hold_c = 1'b1;
    repeat (3) tick();
    hold_c = 1'b0;
    probe(763, 310, 1'b1);
    chk("hold", 32'(c_sum), 32'h0ab);
    @(negedge clk) vs_c = 1'b0;
    repeat (6 * 1040) @(negedge clk);
    vs_c = 1'b1;
    probe(758, 315, 1'b1);
    chk("long_vs", 32'(c_sum), 32'h0ab);
    for (int k = 4; k <= 150; k++) begin
      tick();
      ex = -1; ey = -1;
      case (k)
        54:  begin ex = 503; ey = 568; end
        55:  begin ex = 498; ey = 563; end
        148: begin ex = 33;  ey = 98;  end
        149: begin ex = 32;  ey = 93;  end
        150: begin ex = 37;  ey = 88;  end
        default: ;
      endcase
      if (ex >= 0) begin
        probe(ex, ey, 1'b1);
        chk($sformatf("track_%0d", k), 32'(c_sum), 32'h0ab);
      end
    end

    // asynchronous reset mid-line
    probe(400, 300, 1'b1);
    chk("pre_rst_rgb", 32'(a_rgb), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_rgb", 32'(a_rgb), 0);
    chk("arst_dout", 32'(a_dout), 0);
    chk("arst_sum", 32'(a_sum), 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("refill_rgb", 32'(a_rgb), 0);
    @(posedge clk);
    #1;
    chk("resume_rgb", 32'(a_rgb), 1);
    probe(765, 300, 1'b1);
    chk("start_pos", 32'(c_sum), 32'h0ab);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
